// File: rtl/pkg_system_mdr.sv
// rtl/pkg_system_mdr.sv - shared MDR datapath types, states and width helpers
//
// Purpose : common definitions for the MDR iterative datapath.
// Contents: DATA_W / data_t    - operand word type
//           shr_state_t        - right-shift serializer states
//           step_count_width() - width of a step counter that must hold 0..SDW/SHIFT
package pkg_system_mdr;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    SHR_IDLE,
    SHR_SHIFT,
    SHR_DONE
  } shr_state_t;

  // The counter must reach STEPS itself (not just STEPS-1), hence the +1.
  function automatic int step_count_width(input int sdw, input int shift);
    return $clog2(sdw / shift + 1);
  endfunction

endpackage

// File: rtl/mdr_step_counter.sv
// rtl/mdr_step_counter.sv - saturating step counter with terminal detection
//
// Purpose : counts completed iteration steps, never passing TERMINAL.
// Ports   : clk        - clock, posedge
//           rst        - asynchronous active-low reset, count -> 0
//           i_clear    - synchronous clear to 0 (highest priority)
//           i_load     - synchronous load of i_load_val
//           i_load_val - value loaded by i_load
//           i_incr     - count one step (ignored once at TERMINAL)
//           o_count    - current count
//           o_last     - count == TERMINAL-1, i.e. the next increment is the final one
module mdr_step_counter #(
  parameter int TERMINAL = 32,
  parameter int W        = $clog2(TERMINAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_incr,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_incr && (count_q != W'(TERMINAL))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_last  = (count_q == W'(TERMINAL - 1));

endmodule

// File: rtl/shift_right_operand.sv
// rtl/shift_right_operand.sv - sequential right-shift operand serializer
//
// Purpose : loads an operand, then shifts it right SHIFT bits per enabled step,
//           handing the shifted-out group to the iterative core.
// Ports   : clk      - clock, posedge
//           rst      - asynchronous active-low reset
//           i_val    - operand captured on load
//           i_load   - load i_val and (re)start a sequence
//           i_enable - advance one step while shifting
//           i_clear  - synchronous abort to idle (beats i_load and i_enable)
//           o_val    - remaining operand
//           o_bits   - group shifted out on the most recent step
//           o_busy   - sequence in progress
//           o_done   - one-cycle pulse after the final step
//           o_count  - steps completed in the current sequence
module shift_right_operand
  import pkg_system_mdr::*;
#(
  parameter  int SHIFT = 1,
  parameter  int SDW   = 32,
  localparam int STEPS = SDW / SHIFT,
  localparam int CW    = step_count_width(SDW, SHIFT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SDW-1:0]   i_val,
  input  logic             i_load,
  input  logic             i_enable,
  input  logic             i_clear,
  output data_t            o_val,
  output logic [SHIFT-1:0] o_bits,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_count
);

  shr_state_t       state_q, state_d;
  logic [SDW-1:0]   val_q, val_d;
  logic [SHIFT-1:0] bits_q, bits_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_incr;
  logic             cnt_last;

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    bits_d   = bits_q;
    cnt_incr = 1'b0;

    if (i_clear) begin
      state_d = SHR_IDLE;
      val_d   = '0;
      bits_d  = '0;
    end else if (i_load) begin
      // Accepted in every state, including the DONE cycle.
      state_d = SHR_SHIFT;
      val_d   = i_val;
      bits_d  = '0;
    end else begin
      unique case (state_q)
        SHR_SHIFT: begin
          if (i_enable) begin
            val_d    = val_q >> SHIFT;
            bits_d   = val_q[SHIFT-1:0];
            cnt_incr = 1'b1;
            if (cnt_last) begin
              state_d = SHR_DONE;
            end
          end
        end
        SHR_DONE: state_d = SHR_IDLE;
        default:  state_d = SHR_IDLE;
      endcase
    end

    // Flags are registered copies of the next state so they switch with it.
    busy_d = (state_d == SHR_SHIFT);
    done_d = (state_d == SHR_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SHR_IDLE;
      val_q   <= '0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bits_q  <= bits_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Load always restarts the count at zero, so the load value is fixed.
  mdr_step_counter #(
    .TERMINAL (STEPS),
    .W        (CW)
  ) u_step_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (i_clear),
    .i_load     (i_load),
    .i_load_val ({CW{1'b0}}),
    .i_incr     (cnt_incr),
    .o_count    (o_count),
    .o_last     (cnt_last)
  );

  assign o_val  = val_q;
  assign o_bits = bits_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_shift_right_operand.sv
// tb/tb_shift_right_operand.sv - self-checking bench for shift_right_operand
module tb_shift_right_operand;
  import pkg_system_mdr::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_val;
  logic        i_load, i_enable, i_clear;

  data_t       s1_val, s4_val;
  logic [0:0]  s1_bits;
  logic [3:0]  s4_bits;
  logic        s1_busy, s4_busy, s1_done, s4_done;
  logic [5:0]  s1_cnt;
  logic [3:0]  s4_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_right_operand #(.SHIFT(1), .SDW(32)) u_s1 (
    .clk(clk), .rst(rst), .i_val(i_val), .i_load(i_load), .i_enable(i_enable),
    .i_clear(i_clear), .o_val(s1_val), .o_bits(s1_bits), .o_busy(s1_busy),
    .o_done(s1_done), .o_count(s1_cnt)
  );

  shift_right_operand #(.SHIFT(4), .SDW(32)) u_s4 (
    .clk(clk), .rst(rst), .i_val(i_val), .i_load(i_load), .i_enable(i_enable),
    .i_clear(i_clear), .o_val(s4_val), .o_bits(s4_bits), .o_busy(s4_busy),
    .o_done(s4_done), .o_count(s4_cnt)
  );

  // Reference model: the loaded operand plus the number of steps taken.
  // Every output is derived from those two with plain arithmetic.
  int unsigned     sh [2] = '{1, 4};
  longint unsigned m_orig [2];
  int              m_cnt [2];
  bit              m_active [2];
  bit              m_done [2];

  function automatic logic [31:0] exp_val(input int k);
    return 32'(m_orig[k] >> (sh[k] * m_cnt[k]));
  endfunction

  function automatic logic [31:0] exp_bits(input int k);
    longint unsigned mask;
    mask = (64'd1 << sh[k]) - 1;
    if (m_cnt[k] == 0) return 32'd0;
    return 32'((m_orig[k] >> (sh[k] * (m_cnt[k] - 1))) & mask);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_orig[k] = 0; m_cnt[k] = 0; m_active[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (i_clear) begin
        m_orig[k] = 0; m_cnt[k] = 0; m_active[k] = 0;
      end else if (i_load) begin
        m_orig[k] = {32'd0, i_val}; m_cnt[k] = 0; m_active[k] = 1;
      end else if (m_active[k] && i_enable) begin
        m_cnt[k]++;
        if (m_cnt[k] == 32 / sh[k]) begin
          m_active[k] = 0;
          m_done[k]   = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("s1_val",   s1_val,              exp_val(0));
    chk("s1_bits",  {31'd0, s1_bits},    exp_bits(0));
    chk("s1_busy",  {31'd0, s1_busy},    {31'd0, m_active[0]});
    chk("s1_done",  {31'd0, s1_done},    {31'd0, m_done[0]});
    chk("s1_count", {26'd0, s1_cnt},     32'(m_cnt[0]));
    chk("s4_val",   s4_val,              exp_val(1));
    chk("s4_bits",  {28'd0, s4_bits},    exp_bits(1));
    chk("s4_busy",  {31'd0, s4_busy},    {31'd0, m_active[1]});
    chk("s4_done",  {31'd0, s4_done},    {31'd0, m_done[1]});
    chk("s4_count", {28'd0, s4_cnt},     32'(m_cnt[1]));
  endtask

  // Inputs change just after a negedge; outputs are checked at the next negedge.
  task automatic cyc(input logic ld, input logic en, input logic cl, input logic [31:0] v);
    i_load = ld; i_enable = en; i_clear = cl; i_val = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  logic [3:0] nib [8];
  int         j, dones;

  initial begin
    nib = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    rst = 1'b0; i_load = 0; i_enable = 0; i_clear = 0; i_val = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // SHIFT=1 walk of 0x80000001 with continuous enable
    cyc(1, 0, 0, 32'h8000_0001);
    for (int s = 1; s <= 32; s++) begin
      cyc(0, 1, 0, 0);
      if (s == 1) begin
        chk("s1_step1_bits", {31'd0, s1_bits}, 32'd1);
        chk("s1_step1_val", s1_val, 32'h4000_0000);
      end
      if (s == 31) chk("s1_step31_val", s1_val, 32'h0000_0001);
    end
    chk("s1_step32_bits", {31'd0, s1_bits}, 32'd1);
    chk("s1_step32_val", s1_val, 32'd0);
    chk("s1_done_pulse", {31'd0, s1_done}, 32'd1);
    chk("s1_done_count", {26'd0, s1_cnt}, 32'd32);
    cyc(0, 1, 0, 0);
    chk("s1_done_gone", {31'd0, s1_done}, 32'd0);

    // SHIFT=4 nibble order of 0xDEADBEEF
    cyc(1, 0, 0, 32'hDEAD_BEEF);
    for (int s = 0; s < 8; s++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("s4_nib%0d", s), {28'd0, s4_bits}, {28'd0, nib[s]});
    end
    chk("s4_done_pulse", {31'd0, s4_done}, 32'd1);
    chk("s4_done_notbusy", {31'd0, s4_busy}, 32'd0);

    // enable every third cycle
    cyc(1, 0, 0, 32'h1234_5678);
    j = 0; dones = 0;
    for (int i = 0; i < 27; i++) begin
      cyc(0, (i % 3) == 2, 0, 0);
      if (s4_done) dones++;
      if ((i % 3) == 2 && j < 8) begin
        j++;
        chk("gap_bits", {28'd0, s4_bits}, 32'(9 - j));
      end
    end
    chk("gap_dones", 32'(dones), 32'd1);

    // reload mid-sequence
    cyc(1, 0, 0, 32'hFFFF_FFFF);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 32'h0000_000A);
    chk("reload_cnt", {28'd0, s4_cnt}, 32'd0);
    chk("reload_val", s4_val, 32'hA);
    chk("reload_done", {31'd0, s4_done}, 32'd0);
    cyc(0, 1, 0, 0);
    chk("reload_bits", {28'd0, s4_bits}, 32'hA);

    // clear beats load
    cyc(1, 0, 0, 32'hCAFE_F00D);
    repeat (2) cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 32'h5555_5555);
    chk("clr_busy", {31'd0, s4_busy}, 32'd0);
    chk("clr_val", s4_val, 32'd0);
    repeat (3) cyc(0, 1, 0, 0);
    chk("clr_idle_cnt", {28'd0, s4_cnt}, 32'd0);

    // asynchronous reset at step 5
    cyc(1, 0, 0, 32'h1357_9BDF);
    repeat (5) cyc(0, 1, 0, 0);
    i_enable = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("arst_val", s4_val, 32'd0);
    chk("arst_cnt", {28'd0, s4_cnt}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    cyc(1, 0, 0, 32'h2468_ACE0);
    dones = 0;
    for (int i = 0; i < 33; i++) begin
      cyc(0, 1, 0, 0);
      if (s4_done) dones++;
    end
    chk("arst_rerun_dones", 32'(dones), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 39) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_right_operand.md
Name: shift_right_operand

Overview:
- Sequential right-shift serializer for the MDR datapath; the counterpart of the left-shifting quotient register.
- Loads an operand once, then shifts it right by SHIFT bits per enabled step.
- Presents the bits shifted out each step to the iterative core, plus the remaining value.
- Tracks the step count and signals completion with a busy level and a one-cycle done pulse.

Parameters:
- SHIFT, 1, bits shifted per enabled step; must be ≥ 1 and divide SDW exactly.
- SDW, 32, operand width; must equal the width of data_t in pkg_system_mdr.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset.
- i_val, input, SDW, operand captured on load.
- i_load, input, 1, load i_val and start a new sequence.
- i_enable, input, 1, advance one shift step while shifting.
- i_clear, input, 1, synchronous abort to idle.
- o_val, output, data_t, remaining (shifted) operand.
- o_bits, output, SHIFT, bits shifted out on the most recent step; LSB-first group.
- o_busy, output, 1, high while in SHIFT state.
- o_done, output, 1, one-cycle pulse after the final step.
- o_count, output, $clog2(SDW/SHIFT+1), steps completed in the current sequence.

Behaviour:
- Reset: rst low asynchronously forces state IDLE, o_val=0, o_bits=0, o_busy=0, o_done=0, o_count=0. All outputs are registered.
- Constant: STEPS = SDW/SHIFT.
- Priority at each edge: i_clear > i_load > i_enable.
- i_clear (any state): next state IDLE, all outputs return to reset values.
- IDLE:
  - i_load=1: o_val<=i_val, o_bits<=0, o_count<=0, state->SHIFT, o_busy=1 from the next cycle.
  - i_enable is ignored in IDLE.
- SHIFT:
  - i_enable=1: o_val<=o_val>>SHIFT (logical, zero fill), o_bits<=o_val[SHIFT-1:0], o_count<=o_count+1.
  - If that step was step STEPS (o_count==STEPS-1 before the edge): state->DONE.
  - i_enable=0: all outputs hold.
  - i_load=1: restart. Reload i_val, o_count<=0, stay in SHIFT, no done pulse.
- DONE (exactly one cycle):
  - o_done=1, o_busy=0, o_val=0, o_count=STEPS, o_bits holds the last group.
  - Next state is IDLE.
  - i_load in DONE is accepted: loads, goes to SHIFT, and o_done still pulses this cycle only.
- Latency: load at edge N; first shift possible at edge N+1. With continuous enable, o_done is high in the cycle after edge N+STEPS.
- Enable gaps stretch the sequence; there are no lost or duplicated steps.
- o_count never exceeds STEPS and never wraps.
- Reset mid-sequence: immediate return to reset values; no done pulse.

Decomposition:
- pkg_system_mdr gains:
  - shr_state_t enum {SHR_IDLE, SHR_SHIFT, SHR_DONE};
  - constant/function computing the step-count width from SDW and SHIFT.
- data_t is reused from the package unchanged.
- One sub-module is natural: mdr_step_counter.
  - Parameterized terminal count, with clear/load/increment inputs and a terminal flag.
  - Same clk/rst convention.
  - Reusable by the quotient side.
- FSM and shift register stay in the top module.

Test Plan:
- SHIFT=1, SDW=32: load 0x8000_0001, continuous enable.
  - Step 1: o_bits=1, o_val=0x4000_0000.
  - Step 31: o_val=0x0000_0001.
  - Step 32: o_bits=1, o_val=0.
  - o_done one cycle later, o_count=32.
- SHIFT=4: load 0xDEADBEEF, continuous enable.
  - o_bits sequence F,E,E,B,D,A,E,D.
  - o_done after 8 steps; o_busy low in the done cycle.
- Enable gaps: SHIFT=4, load 0x12345678, enable every third cycle.
  - Outputs hold between steps.
  - o_bits sequence 8,7,6,5,4,3,2,1; exactly one o_done.
- Reload mid-sequence: after 3 steps of 0xFFFFFFFF (SHIFT=4), load 0x0000000A.
  - o_count=0, o_val=0xA, no done.
  - First step gives o_bits=A.
- Clear vs load: i_clear and i_load high together mid-shift.
  - Result is IDLE with all outputs 0, and subsequent enables are ignored.
- Async reset at step 5: outputs zero without a clock edge, o_done never asserted; a following load runs a normal full sequence.
